// File: rtl/ex_operand_stage_if.sv
// ID -> EX operand-stage bus: decoded ID fields, pipeline control, producer
// write-back buses and the EX-side operand/control outputs.
interface ex_operand_stage_if #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int OPW  = 4
);
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [REGW-1:0] id_rs1, id_rs2, id_rd;
    logic            id_rs1_used, id_rs2_used;
    logic [XLEN-1:0] id_rd1, id_rd2, id_imm;
    logic [OPW-1:0]  id_alu_op;
    logic            id_alua_sel, id_alub_sel;
    logic            id_reg_we, id_mem_we, id_mem_re;
    logic [1:0]      id_wb_sel;
    logic            stall, flush;
    logic [REGW-1:0] exm_rd;
    logic            exm_reg_we, exm_mem_re;
    logic [XLEN-1:0] exm_result;
    logic [REGW-1:0] wb_rd;
    logic            wb_reg_we;
    logic [XLEN-1:0] wb_result;

    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_alu_a, ex_alu_b, ex_imm, ex_store_data;
    logic [OPW-1:0]  ex_alu_op;
    logic [REGW-1:0] ex_rd;
    logic            ex_reg_we, ex_mem_we, ex_mem_re;
    logic [1:0]      ex_wb_sel;
    logic            load_use_stall;

    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_used, id_rs2_used,
               id_rd1, id_rd2, id_imm, id_alu_op, id_alua_sel, id_alub_sel,
               id_reg_we, id_mem_we, id_mem_re, id_wb_sel, stall, flush,
               exm_rd, exm_reg_we, exm_mem_re, exm_result,
               wb_rd, wb_reg_we, wb_result,
        input  ex_valid, ex_pc, ex_alu_a, ex_alu_b, ex_imm, ex_store_data,
               ex_alu_op, ex_rd, ex_reg_we, ex_mem_we, ex_mem_re, ex_wb_sel,
               load_use_stall
    );

    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_used, id_rs2_used,
               id_rd1, id_rd2, id_imm, id_alu_op, id_alua_sel, id_alub_sel,
               id_reg_we, id_mem_we, id_mem_re, id_wb_sel, stall, flush,
               exm_rd, exm_reg_we, exm_mem_re, exm_result,
               wb_rd, wb_reg_we, wb_result,
        output ex_valid, ex_pc, ex_alu_a, ex_alu_b, ex_imm, ex_store_data,
               ex_alu_op, ex_rd, ex_reg_we, ex_mem_we, ex_mem_re, ex_wb_sel,
               load_use_stall
    );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and
// self-inserted load-use bubbles.
module ex_operand_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int OPW  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    ex_operand_stage_if.slave  bus
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [OPW-1:0]  alu_op;
        logic            alua_sel;
        logic            alub_sel;
        logic            reg_we;
        logic            mem_we;
        logic            mem_re;
        logic [1:0]      wb_sel;
    } ex_reg_t;

    ex_reg_t         ex_q, ex_d;
    logic            exm_hit1, exm_hit2, wb_hit1, wb_hit2;
    logic            wt1, wt2, load_use;
    logic [XLEN-1:0] fwd1, fwd2;

    // A load in EX/MEM has no data yet, so it never forwards; x0 never forwards.
    always_comb begin
        exm_hit1 = bus.exm_reg_we & ~bus.exm_mem_re & (bus.exm_rd != '0) & (bus.exm_rd == ex_q.rs1);
        exm_hit2 = bus.exm_reg_we & ~bus.exm_mem_re & (bus.exm_rd != '0) & (bus.exm_rd == ex_q.rs2);
        wb_hit1  = bus.wb_reg_we & (bus.wb_rd != '0) & (bus.wb_rd == ex_q.rs1);
        wb_hit2  = bus.wb_reg_we & (bus.wb_rd != '0) & (bus.wb_rd == ex_q.rs2);
        fwd1     = exm_hit1 ? bus.exm_result : wb_hit1 ? bus.wb_result : ex_q.rd1;
        fwd2     = exm_hit2 ? bus.exm_result : wb_hit2 ? bus.wb_result : ex_q.rd2;
        wt1      = bus.wb_reg_we & (bus.wb_rd != '0) & (bus.wb_rd == bus.id_rs1);
        wt2      = bus.wb_reg_we & (bus.wb_rd != '0) & (bus.wb_rd == bus.id_rs2);
        load_use = ex_q.valid & ex_q.mem_re & (ex_q.rd != '0) & bus.id_valid &
                   ((bus.id_rs1_used & (bus.id_rs1 == ex_q.rd)) |
                    (bus.id_rs2_used & (bus.id_rs2 == ex_q.rd)));
    end

    always_comb begin
        ex_d = ex_q;
        if (bus.flush) begin
            ex_d = '0;
        end else if (bus.stall) begin
            // Re-latch forwarded operands so a producer retiring mid-stall is kept.
            ex_d.rd1 = fwd1;
            ex_d.rd2 = fwd2;
        end else if (load_use || !bus.id_valid) begin
            ex_d = '0;
        end else begin
            ex_d.valid    = 1'b1;
            ex_d.pc       = bus.id_pc;
            ex_d.rs1      = bus.id_rs1;
            ex_d.rs2      = bus.id_rs2;
            ex_d.rd       = bus.id_rd;
            ex_d.rd1      = wt1 ? bus.wb_result : bus.id_rd1;
            ex_d.rd2      = wt2 ? bus.wb_result : bus.id_rd2;
            ex_d.imm      = bus.id_imm;
            ex_d.alu_op   = bus.id_alu_op;
            ex_d.alua_sel = bus.id_alua_sel;
            ex_d.alub_sel = bus.id_alub_sel;
            ex_d.reg_we   = bus.id_reg_we;
            ex_d.mem_we   = bus.id_mem_we;
            ex_d.mem_re   = bus.id_mem_re;
            ex_d.wb_sel   = bus.id_wb_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ex_q <= '0;
        else        ex_q <= ex_d;
    end

    assign bus.ex_valid       = ex_q.valid;
    assign bus.ex_pc          = ex_q.pc;
    assign bus.ex_alu_a       = ex_q.alua_sel ? ex_q.pc : fwd1;
    assign bus.ex_alu_b       = ex_q.alub_sel ? ex_q.imm : fwd2;
    assign bus.ex_imm         = ex_q.imm;
    assign bus.ex_store_data  = fwd2;
    assign bus.ex_alu_op      = ex_q.alu_op;
    assign bus.ex_rd          = ex_q.rd;
    assign bus.ex_reg_we      = ex_q.reg_we;
    assign bus.ex_mem_we      = ex_q.mem_we;
    assign bus.ex_mem_re      = ex_q.mem_re;
    assign bus.ex_wb_sel      = ex_q.wb_sel;
    assign bus.load_use_stall = load_use;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed self-checking bench for ex_operand_stage: reset, forwarding,
// load-use bubbles, write-through, stall re-latch, flush and immediate select.
module tb_ex_operand_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    ex_operand_stage_if bus ();
    ex_operand_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_bus();
        bus.id_valid = 0; bus.id_pc = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
        bus.id_rs1_used = 0; bus.id_rs2_used = 0; bus.id_rd1 = 0; bus.id_rd2 = 0;
        bus.id_imm = 0; bus.id_alu_op = 0; bus.id_alua_sel = 0; bus.id_alub_sel = 0;
        bus.id_reg_we = 0; bus.id_mem_we = 0; bus.id_mem_re = 0; bus.id_wb_sel = 0;
        bus.stall = 0; bus.flush = 0;
        bus.exm_rd = 0; bus.exm_reg_we = 0; bus.exm_mem_re = 0; bus.exm_result = 0;
        bus.wb_rd = 0; bus.wb_reg_we = 0; bus.wb_result = 0;
    endtask

    task automatic set_id(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [31:0] rd1, input logic [31:0] rd2);
        bus.id_valid = 1; bus.id_pc = pc; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
        bus.id_rs1_used = 1; bus.id_rs2_used = 1; bus.id_rd1 = rd1; bus.id_rd2 = rd2;
        bus.id_imm = 0; bus.id_alu_op = 0; bus.id_alua_sel = 0; bus.id_alub_sel = 0;
        bus.id_reg_we = 1; bus.id_mem_we = 0; bus.id_mem_re = 0; bus.id_wb_sel = 0;
    endtask

    task automatic test_reset();
        clear_bus();
        #3;
        n_checks++; if (bus.ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", bus.ex_valid); end
        n_checks++; if (bus.ex_alu_a !== 32'h0 || bus.ex_alu_b !== 32'h0 || bus.ex_store_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: a=%h b=%h sd=%h exp 0", bus.ex_alu_a, bus.ex_alu_b, bus.ex_store_data); end
        n_checks++; if (bus.ex_alu_op !== 4'h0 || bus.ex_reg_we !== 1'b0 || bus.ex_mem_we !== 1'b0 || bus.ex_mem_re !== 1'b0 || bus.load_use_stall !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl: op=%h we=%b mwe=%b mre=%b lus=%b exp 0", bus.ex_alu_op, bus.ex_reg_we, bus.ex_mem_we, bus.ex_mem_re, bus.load_use_stall); end
        set_id(32'h40, 5'd1, 5'd2, 5'd3, 32'hAB, 32'hCD);
        rst_n = 1;
        step();
        n_checks++; if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 32'h40 || bus.ex_alu_a !== 32'hAB) begin n_fail++; $display("FAIL reset_first_capture: v=%b pc=%h a=%h exp 1 00000040 000000ab", bus.ex_valid, bus.ex_pc, bus.ex_alu_a); end
        #2 rst_n = 0;
        #1;
        n_checks++; if (bus.ex_valid !== 1'b0 || bus.ex_pc !== 32'h0 || bus.ex_alu_a !== 32'h0 || bus.ex_reg_we !== 1'b0) begin n_fail++; $display("FAIL reset_async: v=%b pc=%h a=%h we=%b exp 0", bus.ex_valid, bus.ex_pc, bus.ex_alu_a, bus.ex_reg_we); end
        #1 rst_n = 1;
        step();
        n_checks++; if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 32'h40 || bus.ex_alu_b !== 32'hCD) begin n_fail++; $display("FAIL reset_post_capture: v=%b pc=%h b=%h exp 1 00000040 000000cd", bus.ex_valid, bus.ex_pc, bus.ex_alu_b); end
    endtask

    task automatic test_exm_fwd();
        clear_bus();
        set_id(32'h100, 5'd5, 5'd6, 5'd9, 32'h11, 32'h22);
        step();
        n_checks++; if (bus.ex_alu_a !== 32'h11) begin n_fail++; $display("FAIL fwd_none: ex_alu_a=%h exp 00000011", bus.ex_alu_a); end
        bus.exm_rd = 5; bus.exm_reg_we = 1; bus.exm_result = 32'hA5A5_0000;
        bus.wb_rd = 5; bus.wb_reg_we = 1; bus.wb_result = 32'h1234;
        #1;
        n_checks++; if (bus.ex_alu_a !== 32'hA5A5_0000) begin n_fail++; $display("FAIL fwd_exm_priority: ex_alu_a=%h exp a5a50000", bus.ex_alu_a); end
        bus.exm_rd = 0;
        #1;
        n_checks++; if (bus.ex_alu_a !== 32'h1234) begin n_fail++; $display("FAIL fwd_wb: ex_alu_a=%h exp 00001234", bus.ex_alu_a); end
        bus.exm_rd = 5; bus.exm_mem_re = 1;
        #1;
        n_checks++; if (bus.ex_alu_a !== 32'h1234) begin n_fail++; $display("FAIL fwd_exm_load_skip: ex_alu_a=%h exp 00001234", bus.ex_alu_a); end
        bus.exm_reg_we = 0; bus.wb_rd = 0;
        #1;
        n_checks++; if (bus.ex_alu_a !== 32'h11) begin n_fail++; $display("FAIL fwd_x0_never: ex_alu_a=%h exp 00000011", bus.ex_alu_a); end
    endtask

    task automatic test_load_use();
        clear_bus();
        set_id(32'h200, 5'd2, 5'd0, 5'd7, 32'h0, 32'h0);
        bus.id_mem_re = 1; bus.id_rs2_used = 0; bus.id_wb_sel = 2'd1;
        step();
        set_id(32'h204, 5'd7, 5'd1, 5'd8, 32'h0, 32'h5);
        #1;
        n_checks++; if (bus.load_use_stall !== 1'b1) begin n_fail++; $display("FAIL lu_detect: load_use_stall=%b exp 1", bus.load_use_stall); end
        bus.id_rs1_used = 0;
        #1;
        n_checks++; if (bus.load_use_stall !== 1'b0) begin n_fail++; $display("FAIL lu_unused_src: load_use_stall=%b exp 0", bus.load_use_stall); end
        bus.id_rs1_used = 1;
        step();
        n_checks++; if (bus.ex_valid !== 1'b0 || bus.ex_reg_we !== 1'b0 || bus.ex_rd !== 5'd0) begin n_fail++; $display("FAIL lu_bubble: v=%b we=%b rd=%0d exp 0 0 0", bus.ex_valid, bus.ex_reg_we, bus.ex_rd); end
        bus.wb_rd = 7; bus.wb_reg_we = 1; bus.wb_result = 32'hCAFE;
        step();
        bus.wb_reg_we = 0; bus.wb_rd = 0;
        #1;
        n_checks++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd8 || bus.ex_alu_a !== 32'hCAFE || bus.ex_alu_b !== 32'h5) begin n_fail++; $display("FAIL lu_replay: v=%b rd=%0d a=%h b=%h exp 1 8 0000cafe 00000005", bus.ex_valid, bus.ex_rd, bus.ex_alu_a, bus.ex_alu_b); end
    endtask

    task automatic test_write_through();
        clear_bus();
        set_id(32'h300, 5'd1, 5'd3, 5'd4, 32'h10, 32'h0);
        bus.wb_rd = 3; bus.wb_reg_we = 1; bus.wb_result = 32'h77;
        step();
        bus.wb_rd = 0; bus.wb_reg_we = 0; bus.wb_result = 0;
        #1;
        n_checks++; if (bus.ex_alu_b !== 32'h77 || bus.ex_store_data !== 32'h77) begin n_fail++; $display("FAIL wt_rs2: b=%h sd=%h exp 00000077", bus.ex_alu_b, bus.ex_store_data); end
        n_checks++; if (bus.ex_alu_a !== 32'h10) begin n_fail++; $display("FAIL wt_rs1_untouched: a=%h exp 00000010", bus.ex_alu_a); end
    endtask

    task automatic test_stall();
        clear_bus();
        set_id(32'h400, 5'd4, 5'd0, 5'd10, 32'h1, 32'h0);
        bus.id_alu_op = 4'h3;
        step();
        bus.stall = 1;
        set_id(32'h404, 5'd2, 5'd0, 5'd11, 32'h2, 32'h0);
        bus.id_alu_op = 4'h5;
        bus.wb_rd = 4; bus.wb_reg_we = 1; bus.wb_result = 32'h99;
        #1;
        n_checks++; if (bus.ex_alu_a !== 32'h99) begin n_fail++; $display("FAIL stall_fwd: a=%h exp 00000099", bus.ex_alu_a); end
        step();
        bus.wb_reg_we = 0; bus.wb_rd = 0; bus.wb_result = 0;
        #1;
        n_checks++; if (bus.ex_alu_a !== 32'h99) begin n_fail++; $display("FAIL stall_relatch: a=%h exp 00000099", bus.ex_alu_a); end
        n_checks++; if (bus.ex_pc !== 32'h400 || bus.ex_rd !== 5'd10 || bus.ex_alu_op !== 4'h3 || bus.ex_reg_we !== 1'b1 || bus.ex_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold_ctrl: pc=%h rd=%0d op=%h we=%b v=%b exp 00000400 10 3 1 1", bus.ex_pc, bus.ex_rd, bus.ex_alu_op, bus.ex_reg_we, bus.ex_valid); end
        step();
        n_checks++; if (bus.ex_alu_a !== 32'h99 || bus.ex_pc !== 32'h400) begin n_fail++; $display("FAIL stall_cycle2: a=%h pc=%h exp 00000099 00000400", bus.ex_alu_a, bus.ex_pc); end
        bus.stall = 0;
        step();
        n_checks++; if (bus.ex_pc !== 32'h404 || bus.ex_alu_op !== 4'h5 || bus.ex_alu_a !== 32'h2) begin n_fail++; $display("FAIL stall_release: pc=%h op=%h a=%h exp 00000404 5 00000002", bus.ex_pc, bus.ex_alu_op, bus.ex_alu_a); end
    endtask

    task automatic test_flush_stall();
        clear_bus();
        set_id(32'h600, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2);
        bus.id_alu_op = 4'h7; bus.id_mem_we = 1;
        step();
        bus.flush = 1; bus.stall = 1;
        step();
        n_checks++; if (bus.ex_valid !== 1'b0 || bus.ex_reg_we !== 1'b0 || bus.ex_mem_we !== 1'b0 || bus.ex_rd !== 5'd0 || bus.ex_alu_op !== 4'h0 || bus.ex_pc !== 32'h0) begin n_fail++; $display("FAIL flush_over_stall: v=%b we=%b mwe=%b rd=%0d op=%h pc=%h exp all 0", bus.ex_valid, bus.ex_reg_we, bus.ex_mem_we, bus.ex_rd, bus.ex_alu_op, bus.ex_pc); end
        bus.flush = 0; bus.stall = 0; bus.id_valid = 0;
        step();
        n_checks++; if (bus.ex_valid !== 1'b0 || bus.ex_reg_we !== 1'b0) begin n_fail++; $display("FAIL invalid_id_bubble: v=%b we=%b exp 0 0", bus.ex_valid, bus.ex_reg_we); end
    endtask

    task automatic test_imm_sel();
        clear_bus();
        set_id(32'h500, 5'd0, 5'd6, 5'd2, 32'h0, 32'h3);
        bus.id_alua_sel = 1; bus.id_alub_sel = 1; bus.id_imm = 32'hFFFF_FFF0;
        bus.id_mem_we = 1; bus.id_reg_we = 0;
        step();
        bus.exm_rd = 6; bus.exm_reg_we = 1; bus.exm_result = 32'hDEAD_BEEF;
        #1;
        n_checks++; if (bus.ex_alu_b !== 32'hFFFF_FFF0 || bus.ex_imm !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL imm_alu_b: b=%h imm=%h exp fffffff0", bus.ex_alu_b, bus.ex_imm); end
        n_checks++; if (bus.ex_store_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL imm_store_fwd: sd=%h exp deadbeef", bus.ex_store_data); end
        n_checks++; if (bus.ex_alu_a !== 32'h500 || bus.ex_mem_we !== 1'b1) begin n_fail++; $display("FAIL imm_pc_sel: a=%h mwe=%b exp 00000500 1", bus.ex_alu_a, bus.ex_mem_we); end
    endtask

    initial begin
        test_reset();
        test_exm_fwd();
        test_load_use();
        test_write_through();
        test_stall();
        test_flush_stall();
        test_imm_sel();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
